// File: rtl/keypad_emulator_if.sv
// Key-press request channel between a request source and the keypad emulator.
interface keypad_emulator_if;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;

  modport master (output req_valid, output req_key, input req_ready);
  modport slave  (input req_valid, input req_key, output req_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Emulates one contact of a 4x4 matrix keypad: accepts a key code, then plays
// bounce-in, hold, bounce-out and a mandatory open gap onto the scanner's rows/cols.
module keypad_emulator #(
  parameter logic [31:0] HOLD_CYCLES   = 32'd2000000,
  parameter logic [31:0] BOUNCE_CYCLES = 32'd20000,
  parameter logic [31:0] GAP_CYCLES    = 32'd2000000,
  parameter logic        BOUNCE_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  keypad_emulator_if.slave   req,
  input  logic               abort,
  input  logic [3:0]         rows,
  output logic [3:0]         cols,
  output logic               busy,
  output logic               key_done
);

  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

  localparam logic BOUNCE_ON = BOUNCE_EN && (BOUNCE_CYCLES != 32'd0);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  key_q, key_d;
  logic        contact_q, contact_d;
  logic [1:0]  row_idx, col_idx;

  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q + 32'd1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req.req_valid) begin
          key_d   = req.req_key;
          state_d = BOUNCE_ON ? BOUNCE_IN : HOLD;
        end
      end
      BOUNCE_IN:  if (cnt_q == BOUNCE_CYCLES - 32'd1) state_d = HOLD;
      HOLD:       if (cnt_q == HOLD_CYCLES - 32'd1)   state_d = BOUNCE_ON ? BOUNCE_OUT : GAP;
      BOUNCE_OUT: if (cnt_q == BOUNCE_CYCLES - 32'd1) state_d = GAP;
      GAP:        if (cnt_q == GAP_CYCLES - 32'd1)    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (abort && (state_q == BOUNCE_IN || state_q == HOLD || state_q == BOUNCE_OUT))
      state_d = GAP;
    if (state_d != state_q)
      cnt_d = '0;

    // Contact is registered from next-state values so cols never glitches on decode.
    case (state_d)
      HOLD:       contact_d = 1'b1;
      BOUNCE_IN:  contact_d = (cnt_d == BOUNCE_CYCLES - 32'd1) ? 1'b1 : lfsr_d[0];
      BOUNCE_OUT: contact_d = (cnt_d == BOUNCE_CYCLES - 32'd1) ? 1'b0 : lfsr_d[0];
      default:    contact_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= 16'hACE1;
      key_q     <= '0;
      contact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      key_q     <= key_d;
      contact_q <= contact_d;
    end
  end

  // Key code to matrix position: {row, col} of the active-low bits.
  always_comb begin
    case (key_q)
      4'd14:   {row_idx, col_idx} = 4'b00_11;
      4'd0:    {row_idx, col_idx} = 4'b00_10;
      4'd15:   {row_idx, col_idx} = 4'b00_01;
      4'd13:   {row_idx, col_idx} = 4'b00_00;
      4'd7:    {row_idx, col_idx} = 4'b01_11;
      4'd8:    {row_idx, col_idx} = 4'b01_10;
      4'd9:    {row_idx, col_idx} = 4'b01_01;
      4'd12:   {row_idx, col_idx} = 4'b01_00;
      4'd4:    {row_idx, col_idx} = 4'b10_11;
      4'd5:    {row_idx, col_idx} = 4'b10_10;
      4'd6:    {row_idx, col_idx} = 4'b10_01;
      4'd11:   {row_idx, col_idx} = 4'b10_00;
      4'd1:    {row_idx, col_idx} = 4'b11_11;
      4'd2:    {row_idx, col_idx} = 4'b11_10;
      4'd3:    {row_idx, col_idx} = 4'b11_01;
      default: {row_idx, col_idx} = 4'b11_00;
    endcase
  end

  always_comb begin
    cols = 4'b1111;
    if (contact_q && !rows[row_idx])
      cols[col_idx] = 1'b0;
  end

  assign busy          = (state_q != IDLE);
  assign req.req_ready = (state_q == IDLE);
  assign key_done      = (state_q == GAP) && (cnt_q == GAP_CYCLES - 32'd1);

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (bounce off / bounce on) checked
// cycle by cycle against a schedule-based model of a key press.
module tb_keypad_emulator;
  localparam int HOLD = 4;
  localparam int GAP  = 3;
  localparam int BNC  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, abort;
  logic [3:0] req_key, rows;
  bit         sel;

  wire [3:0] cols_n, cols_b;
  wire       busy_n, busy_b, done_n, done_b;

  keypad_emulator_if if_n();
  keypad_emulator_if if_b();
  assign if_n.req_valid = req_valid & ~sel;
  assign if_n.req_key   = req_key;
  assign if_b.req_valid = req_valid & sel;
  assign if_b.req_key   = req_key;

  keypad_emulator #(.HOLD_CYCLES(32'd4), .BOUNCE_CYCLES(32'd8), .GAP_CYCLES(32'd3),
                    .BOUNCE_EN(1'b0)) u_nb (
    .clk(clk), .reset(rst), .req(if_n), .abort(abort), .rows(rows),
    .cols(cols_n), .busy(busy_n), .key_done(done_n));

  keypad_emulator #(.HOLD_CYCLES(32'd4), .BOUNCE_CYCLES(32'd8), .GAP_CYCLES(32'd3),
                    .BOUNCE_EN(1'b1)) u_b (
    .clk(clk), .reset(rst), .req(if_b), .abort(abort), .rows(rows),
    .cols(cols_b), .busy(busy_b), .key_done(done_b));

  wire [3:0] cols_s  = sel ? cols_b : cols_n;
  wire       busy_s  = sel ? busy_b : busy_n;
  wire       done_s  = sel ? done_b : done_n;
  wire       ready_s = sel ? if_b.req_ready : if_n.req_ready;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Keypad map from the key table: row and column index per key code.
  int map_r[16] = '{0,3,3,3,2,2,2,1,1,1,3,2,1,0,0,0};
  int map_c[16] = '{2,3,2,1,3,2,1,3,2,1,0,0,0,0,3,1};

  // Model: each press is a list of per-cycle entries (0 open, 1 closed, 2 random bounce).
  typedef struct { int kind; bit done; bit abortable; } ent_t;
  ent_t        q[$];
  ent_t        cur;
  bit          m_idle = 1'b1;
  logic [3:0]  m_key  = 4'd0;
  logic [15:0] m_lfsr = 16'hACE1;

  task automatic push_n(int n, int kind, bit ab, bit dn);
    ent_t e;
    e.kind = kind; e.abortable = ab; e.done = dn;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic push_gap();
    push_n(GAP - 1, 0, 1'b0, 1'b0);
    push_n(1, 0, 1'b0, 1'b1);
  endtask

  task automatic model_edge();
    if (!rst) begin
      q.delete(); m_idle = 1'b1; m_key = 4'd0; m_lfsr = 16'hACE1;
      return;
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    if (m_idle) begin
      if (req_valid) begin
        m_key = req_key;
        if (sel) begin push_n(BNC - 1, 2, 1'b1, 1'b0); push_n(1, 1, 1'b1, 1'b0); end
        push_n(HOLD, 1, 1'b1, 1'b0);
        if (sel) begin push_n(BNC - 1, 2, 1'b1, 1'b0); push_n(1, 0, 1'b1, 1'b0); end
        push_gap();
        cur = q.pop_front(); m_idle = 1'b0;
      end
    end else if (abort && cur.abortable) begin
      q.delete(); push_gap(); cur = q.pop_front();
    end else if (q.size() == 0) begin
      m_idle = 1'b1;
    end else begin
      cur = q.pop_front();
    end
  endtask

  function automatic logic [3:0] exp_cols();
    logic [3:0] c;
    bit closed;
    c = 4'hF;
    closed = !m_idle && (cur.kind == 1 || (cur.kind == 2 && m_lfsr[0]));
    if (closed && !rows[map_r[m_key]]) c[map_c[m_key]] = 1'b0;
    return c;
  endfunction

  function automatic bit exp_busy();
    return !m_idle;
  endfunction

  function automatic bit exp_done();
    return !m_idle && cur.done;
  endfunction

  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = 1'b0; abort = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    sel = 1'b0; rows = 4'h0; req_key = 4'd0;
    rst = 1'b0; req_valid = 1'b0; abort = 1'b0;
    cyc(); cyc();
    checks++; if (cols_n !== 4'hF) begin errors++; $display("FAIL reset_cols_n got=%b exp=1111", cols_n); end
    checks++; if (cols_b !== 4'hF) begin errors++; $display("FAIL reset_cols_b got=%b exp=1111", cols_b); end
    checks++; if (if_n.req_ready !== 1'b1 || if_b.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", if_n.req_ready, if_b.req_ready); end
    checks++; if (busy_n !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b%b exp=00", busy_n, busy_b); end
    checks++; if (done_n !== 1'b0 || done_b !== 1'b0) begin errors++; $display("FAIL reset_done got=%b%b exp=00", done_n, done_b); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int low_cycles = 0;
    sel = 1'b0; do_reset();
    req_key = 4'd5; req_valid = 1'b1; rows = pat[0];
    cyc();
    req_valid = 1'b0;
    for (int i = 1; i < 14; i++) begin
      checks++; if (cols_s !== exp_cols()) begin errors++; $display("FAIL basic_cols c=%0d got=%b exp=%b", i, cols_s, exp_cols()); end
      checks++; if (busy_s !== exp_busy() || ready_s !== !exp_busy()) begin errors++; $display("FAIL basic_busy c=%0d got=%b/%b exp=%b", i, busy_s, ready_s, exp_busy()); end
      checks++; if (done_s !== exp_done()) begin errors++; $display("FAIL basic_done c=%0d got=%b exp=%b", i, done_s, exp_done()); end
      if (cols_s == 4'b1011) low_cycles++;
      rows = pat[i % 4];
      cyc();
    end
    // One hold cycle lines up with rows=1011 when rows rotate every cycle.
    checks++; if (low_cycles != 1) begin errors++; $display("FAIL basic_low_cycles got=%0d exp=1", low_cycles); end
  endtask

  task automatic test_map_sweep();
    sel = 1'b0; do_reset();
    for (int k = 0; k < 16; k++) begin
      for (int r = 0; r < 4; r++) begin
        rows = ~(4'b0001 << r);
        req_key = 4'(k); req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
          checks++; if (cols_s !== exp_cols()) begin errors++; $display("FAIL map_cols key=%0d r=%0d c=%0d got=%b exp=%b", k, r, i, cols_s, exp_cols()); end
          cyc();
        end
      end
    end
  endtask

  task automatic test_bounce();
    int held = 0;
    sel = 1'b1; do_reset();
    rows = 4'b1110; req_key = 4'd14; req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 26; i++) begin
      checks++; if (cols_s !== exp_cols()) begin errors++; $display("FAIL bounce_cols c=%0d got=%b exp=%b", i, cols_s, exp_cols()); end
      checks++; if (busy_s !== exp_busy() || done_s !== exp_done()) begin errors++; $display("FAIL bounce_ctl c=%0d got=%b%b exp=%b%b", i, busy_s, done_s, exp_busy(), exp_done()); end
      if (i >= BNC - 1 && i < BNC + HOLD && cols_s == 4'b0111) held++;
      cyc();
    end
    // The forced-closed last bounce-in cycle plus the whole hold.
    checks++; if (held != HOLD + 1) begin errors++; $display("FAIL bounce_held got=%0d exp=%0d", held, HOLD + 1); end
  endtask

  task automatic test_abort();
    int pulses = 0;
    sel = 1'b0; do_reset();
    rows = 4'h0; req_key = 4'($urandom_range(0, 15)); req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++; if (cols_s !== 4'hF) begin errors++; $display("FAIL abort_release got=%b exp=1111", cols_s); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cols_s !== exp_cols() || busy_s !== exp_busy() || done_s !== exp_done()) begin errors++; $display("FAIL abort_seq c=%0d got=%b %b%b exp=%b %b%b", i, cols_s, busy_s, done_s, exp_cols(), exp_busy(), exp_done()); end
      if (done_s) pulses++;
      cyc();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL abort_done_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; do_reset();
    rows = 4'h0; req_key = 4'd1; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (exp_busy()) req_key = 4'($urandom_range(0, 15));
      if (i == 8) req_key = 4'd2;
      checks++; if (cols_s !== exp_cols()) begin errors++; $display("FAIL b2b_cols c=%0d got=%b exp=%b", i, cols_s, exp_cols()); end
      checks++; if (ready_s !== !exp_busy() || done_s !== exp_done()) begin errors++; $display("FAIL b2b_ctl c=%0d got=%b%b exp=%b%b", i, ready_s, done_s, !exp_busy(), exp_done()); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b1; do_reset();
    rows = 4'h0; req_key = 4'd9; req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < BNC + 1; i++) cyc();
    checks++; if (cols_s !== exp_cols()) begin errors++; $display("FAIL rstmid_hold got=%b exp=%b", cols_s, exp_cols()); end
    rst = 1'b0;
    cyc();
    checks++; if (cols_s !== 4'hF || busy_s !== 1'b0 || ready_s !== 1'b1 || done_s !== 1'b0) begin errors++; $display("FAIL rstmid got=%b %b%b%b exp=1111 010", cols_s, busy_s, ready_s, done_s); end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin errors++; $display("FAIL rstmid_after c=%0d got=%b%b exp=00", i, busy_s, done_s); end
    end
  endtask

  task automatic test_random();
    sel = 1'b1; do_reset();
    for (int i = 0; i < 900; i++) begin
      if (m_idle && $urandom_range(0, 3) == 0) sel = 1'($urandom_range(0, 1));
      req_valid = ($urandom_range(0, 2) == 0);
      req_key   = 4'($urandom_range(0, 15));
      abort     = ($urandom_range(0, 24) == 0);
      rows      = 4'($urandom_range(0, 15));
      cyc();
      checks++; if (cols_s !== exp_cols()) begin errors++; $display("FAIL rand_cols c=%0d sel=%0d got=%b exp=%b", i, sel, cols_s, exp_cols()); end
      checks++; if (busy_s !== exp_busy() || ready_s !== !exp_busy() || done_s !== exp_done()) begin errors++; $display("FAIL rand_ctl c=%0d sel=%0d got=%b%b%b exp=%b%b%b", i, sel, busy_s, ready_s, done_s, exp_busy(), !exp_busy(), exp_done()); end
    end
    abort = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_map_sweep();
    test_bounce();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_CYCLES, default 32'd2000000, contact-closed duration in clk cycles (minimum 1).
REQ-002 Parameter BOUNCE_CYCLES, default 32'd20000, duration of each bounce phase; 0 = no bounce phase.
REQ-003 Parameter GAP_CYCLES, default 32'd2000000, mandatory open time after release (minimum 1).
REQ-004 Parameter BOUNCE_EN, default 1'b1; 0 = both bounce phases skipped.
REQ-005 clk  input  1  system clock; all state changes on posedge clk.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 req_valid  input  1  key-press request valid.
REQ-008 req_key  input  4  key code to press, values 0-15.
REQ-009 req_ready  output  1  emulator can accept a request.
REQ-010 abort  input  1  force early release of the current press.
REQ-011 rows  input  4  row drive from scanner, active-low.
REQ-012 cols  output  4  column sense to scanner, active-low, idle 4'b1111.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 key_done  output  1  one-cycle pulse when a press sequence completes.

Function
REQ-015 Key map, as (row index r of the low rows bit, col index c of the low cols bit):
- 14:(0,3)  0:(0,2)  15:(0,1)  13:(0,0)
- 7:(1,3)  8:(1,2)  9:(1,1)  12:(1,0)
- 4:(2,3)  5:(2,2)  6:(2,1)  11:(2,0)
- 1:(3,3)  2:(3,2)  3:(3,1)  10:(3,0)
REQ-016 cols[c] SHALL be 0 iff the registered contact is closed and rows[r]==0; every other cols bit is 1.
- This is a combinational path from rows to cols with zero latency.
- It is independent of the value of any other rows bit.
REQ-017 States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
REQ-018 req_ready=1 only in IDLE; a handshake is req_valid&&req_ready on a clock edge.
- On handshake, req_key is latched and the next state is BOUNCE_IN.
- If bounce is disabled (BOUNCE_EN=0 or BOUNCE_CYCLES=0), the next state is HOLD instead.
REQ-019 The cycle counter clears on every state entry; each timed state lasts exactly its parameter count in cycles, then advances:
- BOUNCE_IN -> HOLD
- HOLD -> BOUNCE_OUT (or GAP when bounce is disabled)
- BOUNCE_OUT -> GAP
- GAP -> IDLE
REQ-020 Contact per state:
- IDLE and GAP: open.
- HOLD: closed.
- BOUNCE_IN and BOUNCE_OUT: contact = lfsr[0].
REQ-021 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle in every state; reset seed 16'hACE1; never all-zero.
REQ-022 The last cycle of BOUNCE_IN forces the contact closed; the last cycle of BOUNCE_OUT forces it open.
REQ-023 abort=1 in BOUNCE_IN, HOLD or BOUNCE_OUT: next state is GAP, with the contact open from the next cycle.
- abort is ignored in IDLE and GAP.
REQ-024 key_done=1 for exactly the one cycle in which the state is GAP and the GAP counter has reached its terminal count.
- This pulse SHALL also occur after an abort.
REQ-025 The latched key SHALL NOT change while busy=1; req_key changes outside a handshake have no effect.
REQ-026 Counter width is 32 bits; terminal count is parameter-1; no wrap-around is permitted within a state.

Reset
REQ-027 While reset=0 at a clock edge, the following SHALL hold:
- state=IDLE, counter=0, contact open, latched key=0, lfsr=16'hACE1.
- Following edge: cols=4'b1111, req_ready=1, busy=0, key_done=0.
REQ-028 Reset mid-press SHALL release the contact at that edge; no key_done pulse is generated for the aborted press.

Verification
REQ-029 BOUNCE_EN=0, HOLD=4, GAP=3, rows cycling 1110,1101,1011,0111, req_key=5:
- cols=1011 only while rows=1011 for exactly 4 HOLD cycles.
- key_done pulses at the end of 3 GAP cycles, then req_ready=1.
REQ-030 Full map sweep, bounce off: every key 0-15 with a static row pattern drives exactly the mapped cols bit low.
- Other rows give 4'b1111.
REQ-031 BOUNCE_CYCLES=8, key 14, rows=1110:
- cols[3] toggles per lfsr[0] for 8 cycles, then is held 0 for HOLD, then bounces for 8 cycles, then is 1.
REQ-032 abort asserted in the 2nd HOLD cycle: cols=1111 from the next cycle; GAP lasts GAP_CYCLES; key_done pulses once.
REQ-033 req_valid held high for back-to-back keys 1 and 2:
- Key 2 is accepted only in the cycle after key_done.
- req_ready=0 throughout the first sequence.
REQ-034 reset=0 asserted during HOLD: next cycle cols=1111, busy=0, req_ready=1, key_done=0.
